// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch front end: data width,
// default reset vector, queue entry layout and PC helper functions.
package fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // One instruction queue entry: the fetched word and the address it came from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fq_entry_t;

  // Sequential next word address; wraps naturally at 2^32.
  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

  // Force word alignment by clearing the byte offset.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction queue: push at the tail, pop at the head, flush
// empties it in one cycle. The head entry is read straight from the storage
// registers so decode sees a stable value while stalled.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  fq_entry_t        push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output fq_entry_t        head
);

  fq_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // Pointer and occupancy update; full/empty guards keep the queue consistent
  // even if a caller misbehaves. Flush wins over push and pop.
  always_comb begin
    do_push  = push && !flush && (count_q != CNT_W'(DEPTH));
    do_pop   = pop && (count_q != '0);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Control state; cleared by reset so all queued contents are forgotten.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; no reset needed because count gates validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues sequential word fetches under a credit
// limit, tags in-order responses with their PC, queues them for decode and
// handles redirects by flushing the queue and discarding stale responses.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2,
  localparam int CNT_W  = $clog2(DEPTH) + 1,
  localparam int OUT_W  = $clog2(MAX_OUT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [31:0]      imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [31:0]      imem_rsp_data,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             dec_valid,
  input  logic             dec_ready,
  output logic [31:0]      dec_instr,
  output logic [31:0]      dec_pc,
  output logic [CNT_W-1:0] fq_count
);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      rsp_pc_q, rsp_pc_d;
  logic [OUT_W-1:0] outstanding_q, outstanding_d;
  logic [OUT_W-1:0] discard_cnt_q, discard_cnt_d;

  logic      credit_ok;
  logic      req_fire;
  logic      rsp_fire;
  logic      rsp_drop;
  logic      push;
  logic      pop;
  fq_entry_t push_entry;
  fq_entry_t head;

  // A new fetch is allowed only when a queue slot is reserved for every
  // in-flight request plus this one, so responses can never overflow the queue.
  always_comb begin
    credit_ok = (int'(outstanding_q) < MAX_OUT) &&
                ((int'(fq_count) + int'(outstanding_q)) < DEPTH);
    imem_req_valid = !reset && !redirect_valid && credit_ok;
    imem_req_addr  = fetch_pc_q;
  end

  // Transfer decode, PC tracking, in-flight accounting and stale-response discard.
  always_comb begin
    req_fire = imem_req_valid && imem_req_ready;
    rsp_fire = imem_rsp_valid && (outstanding_q != '0);
    rsp_drop = redirect_valid || (discard_cnt_q != '0);
    push     = rsp_fire && !rsp_drop;
    pop      = dec_valid && dec_ready;

    push_entry.pc    = rsp_pc_q;
    push_entry.instr = imem_rsp_data;

    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    discard_cnt_d = discard_cnt_q;
    outstanding_d = outstanding_q + OUT_W'(req_fire) - OUT_W'(rsp_fire);

    if (redirect_valid) begin
      // Everything still in flight belongs to the old path; a response in
      // this very cycle is already being dropped, so it is not counted again.
      fetch_pc_d    = align_pc(redirect_pc);
      rsp_pc_d      = align_pc(redirect_pc);
      discard_cnt_d = outstanding_q - OUT_W'(rsp_fire);
    end else begin
      if (req_fire) fetch_pc_d = pc_next(fetch_pc_q);
      if (push)     rsp_pc_d   = pc_next(rsp_pc_q);
      if (rsp_fire && (discard_cnt_q != '0)) discard_cnt_d = discard_cnt_q - OUT_W'(1);
    end
  end

  // Front-end state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_cnt_q <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_cnt_q <= discard_cnt_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (fq_count),
    .head      (head)
  );

  assign dec_valid = (fq_count != '0);
  assign dec_instr = head.instr;
  assign dec_pc    = head.pc;

  // A response with nothing in flight indicates a broken memory model.
  a_rsp_has_owner: assert property (@(posedge clk) disable iff (reset)
    imem_rsp_valid |-> (outstanding_q != '0));

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue: an in-order memory model with random
// latency, random redirects and decode stalls. Expected decode entries are
// derived from a program-order PC model with redirect epochs and checked by
// a separate monitor.
module tb_fetch_queue;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int DEPTH   = 4;
  localparam int MAX_OUT = 2;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             imem_req_valid;
  logic             imem_req_ready;
  logic [31:0]      imem_req_addr;
  logic             imem_rsp_valid;
  logic [31:0]      imem_rsp_data;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             dec_valid;
  logic             dec_ready;
  logic [31:0]      dec_instr;
  logic [31:0]      dec_pc;
  logic [CNT_W-1:0] fq_count;

  always #5 clk = ~clk;

  fetch_queue #(
    .RESET_PC (RST_PC),
    .DEPTH    (DEPTH),
    .MAX_OUT  (MAX_OUT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .fq_count       (fq_count)
  );

  typedef struct {
    logic [31:0] addr;   // address the DUT actually requested (memory indexing)
    logic [31:0] mpc;    // address the model says should have been requested
    int          epoch;
    int          due;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  mreq_t pend_q[$];
  exp_t  exp_q[$];

  int errors = 0;
  int checks = 0;

  // stimulus knobs
  int rdy_pct  = 100;
  int rsp_pct  = 100;
  int dec_pct  = 100;
  int redir_pm = 0;
  int lat_min  = 1;
  int lat_max  = 1;
  bit          force_redir = 1'b0;
  logic [31:0] force_pc = 32'h0;

  logic [31:0] model_pc;
  int          epoch = 0;
  int          cyc = 0;
  bit          rsp_now = 1'b0;
  int          pops = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Memory, redirect and decode-ready driver plus request checker.
  initial begin
    mreq_t       r;
    bit          prev_stall;
    logic [31:0] prev_addr;
    prev_stall     = 1'b0;
    prev_addr      = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    dec_ready      = 1'b0;
    model_pc       = RST_PC;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      imem_rsp_valid = 1'b0;
      redirect_valid = 1'b0;
      rsp_now        = 1'b0;
      if (reset) begin
        pend_q.delete();
        model_pc       = RST_PC;
        epoch++;
        imem_req_ready = 1'b0;
        dec_ready      = 1'b0;
      end else begin
        imem_req_ready = ($urandom_range(99) < rdy_pct);
        dec_ready      = ($urandom_range(99) < dec_pct);
        redirect_valid = force_redir || ($urandom_range(999) < redir_pm);
        if (force_redir)
          redirect_pc = force_pc;
        else if ($urandom_range(3) == 0)
          redirect_pc = 32'hFFFF_FFFF - 32'($urandom_range(7));
        else
          redirect_pc = $urandom();
        force_redir = 1'b0;
        if (pend_q.size() > 0 && pend_q[0].due <= cyc && $urandom_range(99) < rsp_pct) begin
          r = pend_q.pop_front();
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = 32'hE000_0000 + r.addr;
          rsp_now        = 1'b1;
          // kept only if issued on the current path and no redirect this cycle
          if (!redirect_valid && r.epoch == epoch)
            exp_q.push_back('{r.mpc, 32'hE000_0000 + r.mpc});
        end
        if (redirect_valid) begin
          epoch++;
          model_pc = {redirect_pc[31:2], 2'b00};
        end
      end
      @(negedge clk);
      if (!reset) begin
        if (redirect_valid) chk("req_valid_during_redirect", 32'(imem_req_valid), 32'd0);
        if (prev_stall && !redirect_valid) begin
          chk("req_valid_held", 32'(imem_req_valid), 32'd1);
          chk("req_addr_held", imem_req_addr, prev_addr);
        end
        if (imem_req_valid)
          chk("credit_outstanding", 32'((pend_q.size() + int'(rsp_now)) < MAX_OUT), 32'd1);
        if (imem_req_valid && imem_req_ready) begin
          chk("req_addr", imem_req_addr, model_pc);
          pend_q.push_back('{imem_req_addr, model_pc, epoch, cyc + int'($urandom_range(lat_max, lat_min))});
          model_pc = model_pc + 32'd4;
        end
        prev_stall = imem_req_valid && !imem_req_ready;
        prev_addr  = imem_req_addr;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // Monitor: compares every decode transfer against the scoreboard.
  initial begin
    exp_t e;
    bit   prev_redir;
    prev_redir = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        prev_redir = 1'b0;
      end else begin
        chk("dec_valid_vs_count", 32'(dec_valid), 32'(fq_count != '0));
        chk("count_bound", 32'(int'(fq_count) <= DEPTH), 32'd1);
        if (prev_redir) chk("flush_empty", 32'(fq_count), 32'd0);
        if (dec_valid && dec_ready) begin
          chk("model_has_entry", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            pops++;
            $display("decode #%0d cycle %0d pc=%h instr=%h (expected pc=%h instr=%h)",
                     pops, cyc, dec_pc, dec_instr, e.pc, e.instr);
            chk("dec_pc", dec_pc, e.pc);
            chk("dec_instr", dec_instr, e.instr);
          end
        end
        prev_redir = redirect_valid;
        if (redirect_valid) exp_q.delete();
      end
    end
  end

  // Reset pulse with output checks while reset is held.
  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_req_addr", imem_req_addr, RST_PC);
    chk("rst_dec_valid", 32'(dec_valid), 32'd0);
    chk("rst_fq_count", 32'(fq_count), 32'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic wait_pending(input int n);
    for (int i = 0; i < 50 && pend_q.size() < n; i++) @(negedge clk);
    chk("pending_reached", 32'(pend_q.size()), 32'(n));
  endtask

  initial begin
    int t_req;
    int t_dec;
    t_req = -1;
    t_dec = -1;

    // power-on reset and basic in-order streaming with 1-cycle memory
    repeat (2) @(posedge clk);
    do_reset();
    for (int i = 0; i < 20 && t_dec < 0; i++) begin
      @(negedge clk);
      if (t_req < 0 && imem_req_valid && imem_req_ready) t_req = cyc;
      if (t_dec < 0 && dec_valid) t_dec = cyc;
    end
    chk("first_dec_latency", 32'(t_dec - t_req), 32'd2);
    repeat (10) @(posedge clk);

    // decode stall: queue fills, credit stops requests, head held
    do_reset();
    dec_pct = 0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("stall_count_full", 32'(fq_count), 32'(DEPTH));
    chk("stall_req_blocked", 32'(imem_req_valid), 32'd0);
    chk("stall_head_pc", dec_pc, RST_PC);
    dec_pct = 100;
    repeat (10) @(posedge clk);

    // redirect with two requests in flight, then redirect to the wrap point
    lat_min = 3;
    lat_max = 3;
    wait_pending(2);
    force_pc = 32'h0000_0100;
    force_redir = 1'b1;
    repeat (12) @(posedge clk);
    lat_min = 1;
    lat_max = 2;
    force_pc = 32'hFFFF_FFFC;
    force_redir = 1'b1;
    repeat (12) @(posedge clk);

    // ready held low: request must stay put
    rdy_pct = 0;
    repeat (6) @(posedge clk);
    rdy_pct = 100;

    // random traffic with a reset in the middle
    rdy_pct  = 70;
    rsp_pct  = 60;
    dec_pct  = 70;
    redir_pm = 30;
    lat_min  = 1;
    lat_max  = 4;
    repeat (1500) @(posedge clk);
    do_reset();
    repeat (1500) @(posedge clk);

    // drain: no new requests, all responses returned, decode everything
    redir_pm = 0;
    rdy_pct  = 0;
    rsp_pct  = 100;
    dec_pct  = 100;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("drain_model_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_pending_empty", 32'(pend_q.size()), 32'd0);
    chk("drain_fq_count", 32'(fq_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the instruction queue entry count (power of two, 2..16).
REQ-003 The block SHALL have parameter MAX_OUT, default 2, meaning the maximum number of outstanding memory requests (1..DEPTH).
REQ-004 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 imem_req_valid  output  1  fetch request valid.
REQ-007 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-008 imem_req_addr  output  32  word-aligned fetch address.
REQ-009 imem_rsp_valid  input  1  instruction word returned; responses arrive in request order, at least 1 cycle after acceptance.
REQ-010 imem_rsp_data  input  32  returned instruction word.
REQ-011 redirect_valid  input  1  branch/flush request from a later stage.
REQ-012 redirect_pc  input  32  new fetch address; bits [1:0] SHALL be ignored and treated as 00.
REQ-013 dec_valid  output  1  queue head valid toward the IF/ID register.
REQ-014 dec_ready  input  1  decode accepts the head (low = stall).
REQ-015 dec_instr  output  32  head instruction word.
REQ-016 dec_pc  output  32  address of the head instruction.
REQ-017 fq_count  output  $clog2(DEPTH)+1  current queue occupancy.

Function
REQ-018 A request SHALL transfer when imem_req_valid and imem_req_ready are both high; a response SHALL transfer when imem_rsp_valid is high (no back-pressure).
REQ-019 imem_req_valid SHALL be high only if redirect_valid is low, outstanding < MAX_OUT and fq_count + outstanding < DEPTH (credit rule), so the queue never overflows.
REQ-020 imem_req_valid and imem_req_addr SHALL stay stable while imem_req_ready is low, unless a redirect occurs.
REQ-021 fetch_pc SHALL advance by 4 (modulo 2^32; 32'hFFFF_FFFC wraps to 0) on each request transfer.
REQ-022 An accepted, non-discarded response SHALL be pushed with pc = rsp_pc, and rsp_pc SHALL then advance by 4 with the same wrap rule.
REQ-023 dec_valid SHALL equal (fq_count != 0); dec_instr/dec_pc SHALL come from the queue head and be held stable while dec_valid && !dec_ready.
REQ-024 A decode transfer (dec_valid && dec_ready) SHALL pop the head; a simultaneous push and pop SHALL leave fq_count unchanged.
REQ-025 Latency: with 1-cycle memory, request transfer in cycle t SHALL give dec_valid in cycle t+2 on an empty queue.
REQ-026 On redirect_valid: the queue SHALL be empty from the next cycle, fetch_pc and rsp_pc SHALL load redirect_pc, and discard_cnt SHALL load outstanding minus (imem_rsp_valid ? 1 : 0).
REQ-027 A response arriving in the redirect cycle, or while discard_cnt > 0, SHALL be dropped, and discard_cnt SHALL decrement by one per dropped response.
REQ-028 A decode transfer in the redirect cycle SHALL complete; a push in that cycle SHALL NOT occur.
REQ-029 outstanding SHALL increment on request transfer, decrement on any response (kept or dropped), and be unchanged when both occur in the same cycle.
REQ-030 A response with outstanding == 0 SHALL be ignored (simulation assertion failure).

Reset
REQ-031 While reset is high: imem_req_valid=0, imem_req_addr=RESET_PC, dec_valid=0, fq_count=0, and fetch_pc, rsp_pc=RESET_PC, outstanding=0, discard_cnt=0.
REQ-032 Reset asserted mid-operation SHALL discard all queue contents and in-flight accounting; the first request after deassertion SHALL be to RESET_PC.

Structure
REQ-033 RESET_PC default, the XLEN=32 width constant and the queue entry typedef {pc[31:0], instr[31:0]} SHALL live in shared package fetch_pkg.
REQ-034 Queue storage SHALL be a separate sub-module fetch_fifo (synchronous FIFO with push, pop, flush, count, registered head); credit, PC and discard logic SHALL stay in fetch_queue.

Verification
REQ-035 Reset, 1-cycle memory returning word 32'hE000_0000+addr, dec_ready=1 -> dec_pc sequence 0,4,8,C; first dec_valid 2 cycles after the first request.
REQ-036 dec_ready=0 for 10 cycles -> fq_count saturates at 4, imem_req_valid low, no overflow, head pc=0 held; release -> in-order drain 0,4,8,C.
REQ-037 Two requests outstanding (0x10, 0x14), redirect_pc=0x100 before either responds -> both responses dropped; next dec_pc=0x100.
REQ-038 Redirect in the same cycle as a response and a decode pop -> that response dropped, pop completes, fq_count=0 next cycle.
REQ-039 Redirect to 0xFFFF_FFFC -> dec_pc 0xFFFF_FFFC then 0x0000_0000.
REQ-040 imem_req_ready held low 5 cycles -> imem_req_addr stable; reset asserted mid-stream -> all outputs return to reset values, next request addr=RESET_PC.
